// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-bank write-back arbiter.
// Optional statistics counters are enabled with the WB_STAT_EN macro.
package wb_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_DEF = 3;
  localparam int STAT_W   = 16;

  localparam logic [4:0]        REG_X0   = 5'd0;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Requester and register-bank signals of the write-back arbiter.
// The slave modport is the arbiter side, master is the unit/bank side.
interface reg_wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wb_hold;
  logic               wb_reg_write;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;

  modport slave (
    input  req_valid, req_addr, req_data, wb_hold,
    output req_ready, wb_reg_write, wb_addr, wb_data
  );

  modport master (
    output req_valid, req_addr, req_data, wb_hold,
    input  req_ready, wb_reg_write, wb_addr, wb_data
  );

endinterface

// File: rtl/reg_wb_arbiter_rr.sv
// Round-robin arbiter: searches upward from the last granted requester.
// The pointer only moves when a grant is actually accepted.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] lastGrant_q, lastGrant_d;
  logic          found;
  int            cand;

  // Grant is forced to zero in reset and while the bank port is held.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(lastGrant_q) + k) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        grant_idx    = IW'(cand);
      end
    end
    if (!en || !rst) begin
      grant = '0;
    end
  end

  always_comb begin
    lastGrant_d = advance ? grant_idx : lastGrant_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lastGrant_q <= IW'(NREQ - 1);
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-bank write port between NREQ write-back sources.
// Define WB_STAT_EN to add per-requester grant and x0-write counters.
module reg_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_wb_arbiter_if.slave        bus
`ifdef WB_STAT_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_grant_cnt,
  output logic [STAT_W-1:0]      stat_x0_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grantIdx;
  logic            transfer;
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selData;
  logic            selIsX0;

  logic            wbRegWrite_q, wbRegWrite_d;
  logic [AW-1:0]   wbAddr_q, wbAddr_d;
  logic [DW-1:0]   wbData_q, wbData_d;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .en        (!bus.wb_hold),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grantIdx)
  );

  assign bus.req_ready = grant;
  assign transfer      = |(bus.req_valid & grant);

  always_comb begin
    selAddr = bus.req_addr[grantIdx*AW +: AW];
    selData = bus.req_data[grantIdx*DW +: DW];
    selIsX0 = (selAddr == AW'(REG_X0));
  end

  // Address/data only follow a transfer; the strobe drops on any idle cycle.
  always_comb begin
    wbRegWrite_d = transfer && !selIsX0;
    wbAddr_d     = transfer ? selAddr : wbAddr_q;
    wbData_d     = transfer ? selData : wbData_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbRegWrite_q <= 1'b0;
      wbAddr_q     <= '0;
      wbData_q     <= '0;
    end else begin
      wbRegWrite_q <= wbRegWrite_d;
      wbAddr_q     <= wbAddr_d;
      wbData_q     <= wbData_d;
    end
  end

  assign bus.wb_reg_write = wbRegWrite_q;
  assign bus.wb_addr      = wbAddr_q;
  assign bus.wb_data      = wbData_q;

`ifdef WB_STAT_EN
  logic [STAT_W-1:0] grantCnt_q [NREQ];
  logic [STAT_W-1:0] x0Cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        grantCnt_q[i] <= '0;
      end
      x0Cnt_q <= '0;
    end else if (transfer) begin
      grantCnt_q[grantIdx] <= satInc(grantCnt_q[grantIdx]);
      if (selIsX0) begin
        x0Cnt_q <= satInc(x0Cnt_q);
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_grant_cnt[i*STAT_W +: STAT_W] = grantCnt_q[i];
    end
  end

  assign stat_x0_cnt = x0Cnt_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations.
// Stat counters are checked too when WB_STAT_EN is defined.
module tb_reg_wb_arbiter;
  import wb_pkg::*;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

`ifdef WB_STAT_EN
  logic [NREQ*STAT_W-1:0] statGrantCnt;
  logic [STAT_W-1:0]      statX0Cnt;
`endif

  reg_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave)
`ifdef WB_STAT_EN
    ,
    .stat_grant_cnt (statGrantCnt),
    .stat_x0_cnt    (statX0Cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [NREQ-1:0] valid, input logic hold);
    rst           = rstVal;
    bus.req_valid = valid;
    bus.wb_hold   = hold;
    #1;
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_addr[i*AW +: AW] = addr;
    bus.req_data[i*DW +: DW] = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    checks = 0;
    errors = 0;
    bus.req_addr = '0;
    bus.req_data = '0;
    setReq(0, 5'd1, 32'h0000_00A1);
    setReq(1, 5'd2, 32'h0000_00A2);
    setReq(2, 5'd3, 32'h0000_00A3);

    applyStimulus(1'b0, 3'b111, 1'b0);
    step();
    step();
    checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_we", 32'(bus.wb_reg_write), 32'h0);
    checkOutput("rst_addr", 32'(bus.wb_addr), 32'h0);
    checkOutput("rst_data", bus.wb_data, 32'h0);

    // Release reset: requester 0 holds top priority first.
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkOutput("rel_ready", 32'(bus.req_ready), 32'h1);
    setReq(0, 5'd7, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'b001, 1'b0);
    checkOutput("single_ready", 32'(bus.req_ready), 32'h1);
    step();
    checkOutput("single_we", 32'(bus.wb_reg_write), 32'h1);
    checkOutput("single_addr", 32'(bus.wb_addr), 32'd7);
    checkOutput("single_data", bus.wb_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'b000, 1'b0);
    checkOutput("idle_ready", 32'(bus.req_ready), 32'h0);
    step();
    checkOutput("idle_we", 32'(bus.wb_reg_write), 32'h0);
    checkOutput("idle_addr_hold", 32'(bus.wb_addr), 32'd7);

    // Pointer sits at 0, so rotation starts at requester 1.
    setReq(0, 5'd1, 32'h0000_00A1);
    applyStimulus(1'b1, 3'b111, 1'b0);
    for (int k = 0; k < 6; k++) begin
      e = (1 + k) % NREQ;
      checkOutput($sformatf("rot_ready%0d", k), 32'(bus.req_ready), 32'(1 << e));
      step();
      checkOutput($sformatf("rot_we%0d", k), 32'(bus.wb_reg_write), 32'h1);
      checkOutput($sformatf("rot_addr%0d", k), 32'(bus.wb_addr), 32'(e + 1));
      checkOutput($sformatf("rot_data%0d", k), bus.wb_data, 32'h0000_00A1 + 32'(e));
    end

    applyStimulus(1'b1, 3'b010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold_ready%0d", k), 32'(bus.req_ready), 32'h0);
      step();
      checkOutput($sformatf("hold_we%0d", k), 32'(bus.wb_reg_write), 32'h0);
    end
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("unhold_ready", 32'(bus.req_ready), 32'h2);
    step();
    checkOutput("unhold_we", 32'(bus.wb_reg_write), 32'h1);
    checkOutput("unhold_addr", 32'(bus.wb_addr), 32'd2);

    // Write to x0: handshake completes, strobe stays low, pointer moves to 2.
    setReq(2, 5'd0, 32'h0000_1234);
    applyStimulus(1'b1, 3'b100, 1'b0);
    checkOutput("x0_ready", 32'(bus.req_ready), 32'h4);
    step();
    checkOutput("x0_we", 32'(bus.wb_reg_write), 32'h0);
    checkOutput("x0_addr", 32'(bus.wb_addr), 32'd0);
    checkOutput("x0_data", bus.wb_data, 32'h0000_1234);
    setReq(2, 5'd3, 32'h0000_00A3);
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkOutput("x0_next_ready", 32'(bus.req_ready), 32'h1);
`ifdef WB_STAT_EN
    checkOutput("stat_x0", 32'(statX0Cnt), 32'd1);
    checkOutput("stat_g0", 32'(statGrantCnt[0*STAT_W +: STAT_W]), 32'd3);
    checkOutput("stat_g1", 32'(statGrantCnt[1*STAT_W +: STAT_W]), 32'd3);
    checkOutput("stat_g2", 32'(statGrantCnt[2*STAT_W +: STAT_W]), 32'd3);
`endif

    step();
    checkOutput("mid_we", 32'(bus.wb_reg_write), 32'h1);
    checkOutput("mid_addr", 32'(bus.wb_addr), 32'd1);
    applyStimulus(1'b0, 3'b111, 1'b0);
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'h0);
    step();
    checkOutput("midrst_we", 32'(bus.wb_reg_write), 32'h0);
    checkOutput("midrst_addr", 32'(bus.wb_addr), 32'h0);
    checkOutput("midrst_data", bus.wb_data, 32'h0);
`ifdef WB_STAT_EN
    checkOutput("midrst_stat_x0", 32'(statX0Cnt), 32'd0);
    checkOutput("midrst_stat_g", 32'(statGrantCnt), 32'd0);
`endif
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkOutput("midrst_ptr", 32'(bus.req_ready), 32'h1);
    applyStimulus(1'b1, 3'b000, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
